// File: rtl/mux_scan_pkg.sv
// Shared types, mode encodings and helpers for the mux_scan_n selector.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2, never below 1 so a 2-channel mux still gets a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// Combinational next-channel finder for the scan pointer.
// With MUX_SCAN_MASK_EN defined it searches upward (mod N) for the next
// enabled channel; otherwise it is a plain ptr+1 mod N.
module mux_scan_ptr
  import mux_scan_pkg::*;
#(
  parameter int N  = 10,
  parameter int SW = 4
) (
  input  logic [SW-1:0] ptr,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]  mask,
`endif
  output logic [SW-1:0] next_ptr,
  output logic          wrapped,
  output logic          none_set
);

`ifdef MUX_SCAN_MASK_EN
  // Scan the channels after ptr in circular order and take the first enabled one.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    next_ptr = ptr;
    wrapped  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && mask[idx]) begin
        found    = 1'b1;
        next_ptr = SW'(idx);
        wrapped  = (int'(ptr) + i) >= N;
      end
    end
    none_set = ~|mask;
  end
`else
  // Step to the next channel, wrapping at N rather than at 2^SW.
  always_comb begin
    if (int'(ptr) >= N - 1) begin
      next_ptr = '0;
      wrapped  = 1'b1;
    end else begin
      next_ptr = ptr + SW'(1);
      wrapped  = 1'b0;
    end
    none_set = 1'b0;
  end
`endif

endmodule

// File: rtl/mux_scan_n.sv
// N-channel, W-bit registered multiplexer with manual select and auto-scan.
// Optional feature macro: MUX_SCAN_MASK_EN adds a per-channel scan mask port.
//
// ptr/cnt describe the sample currently on y: ch == ptr while scanning and
// cnt counts how many extra cycles that channel has already been shown.
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter  int N  = 10,
  parameter  int W  = 1,
  parameter  int DW = 16,
  localparam int SW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N*W-1:0]  din,
  input  logic [DW-1:0]   dwell,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]    mask,
`endif
  output logic [W-1:0]    y,
  output logic            y_valid,
  output logic [SW-1:0]   ch,
  output logic            wrap
);

  logic [W-1:0] chan [N];

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan[k] = din[k*W +: W];
  end

  state_t        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          primed_q, primed_d;
  logic [W-1:0]  y_d;
  logic          y_valid_d;
  logic [SW-1:0] ch_d;
  logic          wrap_d;

  logic          restart;
  logic          sel_ok;
  logic [SW-1:0] search_from;
  logic [SW-1:0] next_ptr;
  logic          wrapped;
  logic          none_set;

  // A scan (re)starts at the first channel after reset or when leaving MANUAL;
  // searching from N-1 makes the finder return the lowest enabled channel.
  assign restart     = (state_q == MANUAL) || !primed_q;
  assign search_from = restart ? SW'(N - 1) : ptr_q;
  assign sel_ok      = int'(sel) < N;

  mux_scan_ptr #(
    .N  (N),
    .SW (SW)
  ) u_ptr (
    .ptr      (search_from),
`ifdef MUX_SCAN_MASK_EN
    .mask     (mask),
`endif
    .next_ptr (next_ptr),
    .wrapped  (wrapped),
    .none_set (none_set)
  );

  // Next state from en/mode, plus next pointer, dwell count and output values.
  always_comb begin
    state_d   = !en ? IDLE : ((mode == MODE_SCAN) ? SCAN : MANUAL);
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    primed_d  = primed_q;
    y_d       = '0;
    y_valid_d = 1'b0;
    ch_d      = ch;
    wrap_d    = 1'b0;

    unique case (state_d)
      IDLE: begin
        // Outputs blank; ch, ptr and cnt freeze.
      end
      MANUAL: begin
        ch_d  = sel;
        cnt_d = '0;
        if (sel_ok) begin
          y_d       = chan[sel];
          y_valid_d = 1'b1;
        end
      end
      SCAN: begin
        if (none_set) begin
          // Every channel masked: blank output, ptr and cnt hold.
        end else if (restart) begin
          ptr_d     = next_ptr;
          cnt_d     = '0;
          primed_d  = 1'b1;
          ch_d      = next_ptr;
          y_d       = chan[next_ptr];
          y_valid_d = 1'b1;
        end else if (cnt_q >= dwell) begin
          // >= so that lowering dwell mid-dwell advances on the next cycle.
          ptr_d     = next_ptr;
          cnt_d     = '0;
          wrap_d    = wrapped;
          ch_d      = next_ptr;
          y_d       = chan[next_ptr];
          y_valid_d = 1'b1;
        end else begin
          // cnt < dwell here, so the increment can never overflow.
          cnt_d     = cnt_q + DW'(1);
          ch_d      = ptr_q;
          y_d       = chan[ptr_q];
          y_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, scan bookkeeping and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      y        <= '0;
      y_valid  <= 1'b0;
      ch       <= '0;
      wrap     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      y        <= y_d;
      y_valid  <= y_valid_d;
      ch       <= ch_d;
      wrap     <= wrap_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed self-checking bench for mux_scan_n (mask tests need MUX_SCAN_MASK_EN).
module tb_mux_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  // N=10, W=4: manual select and modulo-10 scan
  logic        en_man, mode_man;
  logic [3:0]  sel_man;
  logic [39:0] din_man;
  logic [15:0] dwell_man;
  logic [3:0]  y_man, ch_man;
  logic        v_man, wrap_man;

  // N=4, W=4: scan timing, freeze, reset, dwell change
  logic        en_scn, mode_scn;
  logic [1:0]  sel_scn;
  logic [15:0] din_scn;
  logic [7:0]  dwell_scn;
  logic [3:0]  y_scn;
  logic [1:0]  ch_scn;
  logic        v_scn, wrap_scn;

  // N=2, W=1: dwell=0 alternation
  logic        en_two, mode_two;
  logic [0:0]  sel_two;
  logic [1:0]  din_two;
  logic [3:0]  dwell_two;
  logic [0:0]  y_two, ch_two;
  logic        v_two, wrap_two;

  logic [3:0]  scan_val [4];

`ifdef MUX_SCAN_MASK_EN
  logic        en_msk, mode_msk;
  logic [2:0]  sel_msk;
  logic [31:0] din_msk;
  logic [3:0]  dwell_msk;
  logic [7:0]  mask_msk;
  logic [3:0]  y_msk;
  logic [2:0]  ch_msk;
  logic        v_msk, wrap_msk;
  logic [9:0]  mask_man = '1;
  logic [3:0]  mask_scn = '1;
  logic [1:0]  mask_two = '1;
`endif

  mux_scan_n #(.N(10), .W(4), .DW(16)) u_man (
    .clk(clk), .rst(rst), .en(en_man), .mode(mode_man), .sel(sel_man),
    .din(din_man), .dwell(dwell_man),
`ifdef MUX_SCAN_MASK_EN
    .mask(mask_man),
`endif
    .y(y_man), .y_valid(v_man), .ch(ch_man), .wrap(wrap_man)
  );

  mux_scan_n #(.N(4), .W(4), .DW(8)) u_scan (
    .clk(clk), .rst(rst), .en(en_scn), .mode(mode_scn), .sel(sel_scn),
    .din(din_scn), .dwell(dwell_scn),
`ifdef MUX_SCAN_MASK_EN
    .mask(mask_scn),
`endif
    .y(y_scn), .y_valid(v_scn), .ch(ch_scn), .wrap(wrap_scn)
  );

  mux_scan_n #(.N(2), .W(1), .DW(4)) u_two (
    .clk(clk), .rst(rst), .en(en_two), .mode(mode_two), .sel(sel_two),
    .din(din_two), .dwell(dwell_two),
`ifdef MUX_SCAN_MASK_EN
    .mask(mask_two),
`endif
    .y(y_two), .y_valid(v_two), .ch(ch_two), .wrap(wrap_two)
  );

`ifdef MUX_SCAN_MASK_EN
  mux_scan_n #(.N(8), .W(4), .DW(4)) u_msk (
    .clk(clk), .rst(rst), .en(en_msk), .mode(mode_msk), .sel(sel_msk),
    .din(din_msk), .dwell(dwell_msk), .mask(mask_msk),
    .y(y_msk), .y_valid(v_msk), .ch(ch_msk), .wrap(wrap_msk)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    en_man    = 1'b0; mode_man = 1'b0; sel_man = '0; dwell_man = '0;
    en_scn    = 1'b0; mode_scn = 1'b0; sel_scn = '0; dwell_scn = 8'd2;
    en_two    = 1'b0; mode_two = 1'b0; sel_two = '0; dwell_two = '0;
    din_scn   = 16'h9A5F;   // ch0=F ch1=5 ch2=A ch3=9
    din_two   = 2'b10;      // ch0=0 ch1=1
    scan_val  = '{4'hF, 4'h5, 4'hA, 4'h9};
    for (int k = 0; k < 10; k++) din_man[k*4 +: 4] = 4'(k + 3);  // ch7 = A
`ifdef MUX_SCAN_MASK_EN
    en_msk = 1'b0; mode_msk = 1'b0; sel_msk = '0; dwell_msk = '0;
    mask_msk = 8'b1000_0101;
    din_msk  = 32'h7654_3210;  // channel k carries k
`endif

    // Reset held for two cycles, then disabled
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst y",     64'(y_scn),    64'(0));
      check("rst valid", 64'(v_scn),    64'(0));
      check("rst ch",    64'(ch_scn),   64'(0));
      check("rst wrap",  64'(wrap_scn), 64'(0));
      check("rst man y", 64'(y_man),    64'(0));
    end
    rst = 1'b0;
    din_scn = 16'hFFFF;
    step();
    check("idle y",     64'(y_scn), 64'(0));
    check("idle valid", 64'(v_scn), 64'(0));
    check("idle ch",    64'(ch_scn), 64'(0));
    din_scn = 16'h9A5F;

    // Manual select
    en_man = 1'b1; mode_man = 1'b0; sel_man = 4'd7;
    step();
    check("man7 y",     64'(y_man),  64'hA);
    check("man7 valid", 64'(v_man),  64'(1));
    check("man7 ch",    64'(ch_man), 64'(7));
    sel_man = 4'd12;
    step();
    check("man12 y",     64'(y_man),  64'(0));
    check("man12 valid", 64'(v_man),  64'(0));
    check("man12 ch",    64'(ch_man), 64'hC);
    sel_man = 4'd9;
    step();
    check("man9 y", 64'(y_man), 64'hC);
    sel_man = 4'd0;
    step();
    check("man0 y", 64'(y_man), 64'h3);

    // Scan on N=10 with dwell=0: pointer wraps modulo 10
    mode_man = 1'b1; dwell_man = '0;
    for (int i = 0; i < 11; i++) begin
      step();
      check("scan10 ch",   64'(ch_man),   64'(i % 10));
      check("scan10 y",    64'(y_man),    64'((i % 10) + 3));
      check("scan10 wrap", 64'(wrap_man), 64'(i == 10));
    end
    en_man = 1'b0;

    // N=2, dwell=0: alternates, wrap every second cycle
    en_two = 1'b1; mode_two = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("two ch",   64'(ch_two),   64'(i % 2));
      check("two y",    64'(y_two),    64'(i % 2));
      check("two wrap", 64'(wrap_two), 64'((i == 2) || (i == 4)));
    end
    en_two = 1'b0;

    // Scan timing N=4, dwell=2, continuing into the second round
    en_scn = 1'b1; mode_scn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("scan ch",    64'(ch_scn),   64'((i / 3) % 4));
      check("scan y",     64'(y_scn),    64'(scan_val[(i / 3) % 4]));
      check("scan valid", 64'(v_scn),    64'(1));
      check("scan wrap",  64'(wrap_scn), 64'(i == 12));
    end

    // Freeze at ch=2 (second cycle of its dwell) for 5 cycles
    en_scn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("frz y",     64'(y_scn),  64'(0));
      check("frz valid", 64'(v_scn),  64'(0));
      check("frz ch",    64'(ch_scn), 64'(2));
    end
    en_scn = 1'b1;
    step();
    check("resume ch2", 64'(ch_scn), 64'(2));
    check("resume y2",  64'(y_scn),  64'hA);
    step();
    check("resume ch3", 64'(ch_scn), 64'(3));
    step();
    check("dwell ch3",  64'(ch_scn), 64'(3));

    // Reset mid-dwell, then restart at channel 0
    rst = 1'b1;
    step();
    check("midrst ch",    64'(ch_scn), 64'(0));
    check("midrst y",     64'(y_scn),  64'(0));
    check("midrst valid", 64'(v_scn),  64'(0));
    rst = 1'b0;
    step();
    check("restart ch", 64'(ch_scn), 64'(0));
    check("restart y",  64'(y_scn),  64'hF);

    // Dwell lowered from 10 to 3 while cnt=5: advance on the next cycle
    dwell_scn = 8'd10;
    for (int i = 0; i < 5; i++) begin
      step();
      check("dw10 ch", 64'(ch_scn), 64'(0));
    end
    dwell_scn = 8'd3;
    step();
    check("dw3 ch", 64'(ch_scn), 64'(1));
    check("dw3 y",  64'(y_scn),  64'h5);

`ifdef MUX_SCAN_MASK_EN
    // Masked scan: channels 0,2,7 only, wrap back to 0
    en_msk = 1'b1; mode_msk = 1'b1;
    step();
    check("msk ch0",   64'(ch_msk),   64'(0));
    check("msk wrap0", 64'(wrap_msk), 64'(0));
    step();
    check("msk ch2",   64'(ch_msk),   64'(2));
    check("msk y2",    64'(y_msk),    64'(2));
    step();
    check("msk ch7",   64'(ch_msk),   64'(7));
    check("msk wrap7", 64'(wrap_msk), 64'(0));
    step();
    check("msk chw",   64'(ch_msk),   64'(0));
    check("msk wrapw", 64'(wrap_msk), 64'(1));
    mask_msk = 8'h00;
    step();
    check("msk none valid", 64'(v_msk), 64'(0));
    check("msk none y",     64'(y_msk), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
